card_dealer: RTL and testbench

Deck source for the poker game FSM. Holds a 52-card deck in registers, shuffles it on command with an on-chip LFSR (Fisher–Yates), then deals one card per request through a valid-pulse handshake. The game FSM drives `shuffle_start` in its shuffling hand state. It issues `deal_req` once per card while dealing hole cards and community cards, and converts each dealt index to `card_t`.

---
 rtl/card_dealer_if.sv | 21 ++
 rtl/card_dealer.sv | 115 +++++++++++
 tb/tb_card_dealer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// Handshake bundle between the game FSM (master) and the card dealer (slave).
interface card_dealer_if;
    logic       shuffle_start;
    logic       deal_req;
    logic       deal_valid;
    logic [5:0] deal_card;
    logic       deal_err;
    logic       busy;
    logic       ready;
    logic [5:0] cards_left;

    modport master (
        output shuffle_start, deal_req,
        input  deal_valid, deal_card, deal_err, busy, ready, cards_left
    );

    modport slave (
        input  shuffle_start, deal_req,
        output deal_valid, deal_card, deal_err, busy, ready, cards_left
    );
endinterface

// File: rtl/card_dealer.sv
// 52-card deck: rebuilt and Fisher-Yates shuffled from a free-running LFSR,
// then dealt one card per request with a single-cycle valid/err pulse.
module card_dealer #(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter bit          SHUFFLE_EN = 1'b1
) (
    input logic          clk,
    input logic          reset,
    card_dealer_if.slave dif
);
    localparam logic [15:0] SeedEff  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int unsigned NumCards = 52;

    typedef enum logic [1:0] {StIdle, StInit, StShuffle, StReady} state_e;

    state_e      st_q, st_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  deck_q [NumCards];
    logic [5:0]  k_q, i_q, ptr_q, left_q, deal_card_q;
    logic        deal_valid_q, deal_err_q;
    logic [5:0]  mask, cand;
    logic        accept, deal_ok, busy, ready;

    assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    // Smallest all-ones mask covering i, so candidates are rejected at most half the time.
    always_comb begin
        mask = 6'd1;
        if (i_q >= 6'd32)      mask = 6'd63;
        else if (i_q >= 6'd16) mask = 6'd31;
        else if (i_q >= 6'd8)  mask = 6'd15;
        else if (i_q >= 6'd4)  mask = 6'd7;
        else if (i_q >= 6'd2)  mask = 6'd3;
    end

    assign cand    = lfsr_q[5:0] & mask;
    assign accept  = (st_q == StShuffle) && (cand <= i_q);
    assign deal_ok = dif.deal_req && !dif.shuffle_start && (st_q == StReady) && (left_q != 6'd0);

    always_ff @(posedge clk) begin
        if (reset) st_q <= StIdle;
        else       st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        if (dif.shuffle_start) begin
            st_d = StInit;
        end else begin
            case (st_q)
                StInit:    if (k_q == 6'd51) st_d = SHUFFLE_EN ? StShuffle : StReady;
                StShuffle: if (accept && (i_q == 6'd1)) st_d = StReady;
                default:   st_d = st_q;
            endcase
        end
    end

    always_comb begin
        busy  = (st_q == StInit) || (st_q == StShuffle);
        ready = (st_q == StReady);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q       <= SeedEff;
            k_q          <= 6'd0;
            i_q          <= 6'd51;
            ptr_q        <= 6'd0;
            left_q       <= 6'd0;
            deal_card_q  <= 6'd0;
            deal_valid_q <= 1'b0;
            deal_err_q   <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            deal_valid_q <= deal_ok;
            deal_err_q   <= dif.deal_req && !deal_ok;
            if (dif.shuffle_start) begin
                k_q    <= 6'd0;
                i_q    <= 6'd51;
                ptr_q  <= 6'd0;
                left_q <= 6'd0;
            end else begin
                if (st_q == StInit) k_q <= k_q + 6'd1;
                if (accept)         i_q <= i_q - 6'd1;
                if ((st_d == StReady) && (st_q != StReady)) begin
                    left_q <= 6'd52;
                    ptr_q  <= 6'd0;
                end else if (deal_ok) begin
                    deal_card_q <= deck_q[ptr_q];
                    ptr_q       <= ptr_q + 6'd1;
                    left_q      <= left_q - 6'd1;
                end
            end
        end
    end

    // Deck storage has no reset: INIT rewrites every entry before it is ever read.
    always_ff @(posedge clk) begin
        if (!reset && !dif.shuffle_start) begin
            if (st_q == StInit) begin
                deck_q[k_q] <= k_q;
            end else if (accept) begin
                deck_q[i_q]  <= deck_q[cand];
                deck_q[cand] <= deck_q[i_q];
            end
        end
    end

    assign dif.deal_valid = deal_valid_q;
    assign dif.deal_err   = deal_err_q;
    assign dif.deal_card  = deal_card_q;
    assign dif.cards_left = left_q;
    assign dif.busy       = busy;
    assign dif.ready      = ready;
endmodule

// File: tb/tb_card_dealer.sv
// Randomised scoreboard bench for card_dealer: shuffled and in-order instances
// checked against a cycle-counted reference of the deck and LFSR.
module tb_card_dealer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    card_dealer_if s_if ();
    card_dealer_if o_if ();

    card_dealer #(.LFSR_SEED(16'hACE1), .SHUFFLE_EN(1'b1)) dut_s (
        .clk(clk), .reset(reset), .dif(s_if)
    );
    card_dealer #(.LFSR_SEED(16'hACE1), .SHUFFLE_EN(1'b0)) dut_o (
        .clk(clk), .reset(reset), .dif(o_if)
    );

    typedef struct {
        int         cyc;
        bit         err;
        logic [5:0] card;
    } evt_t;

    evt_t        sq[$], oq[$];
    evt_t        es, eo;
    int          n_vec = 0, n_bad = 0;
    int          cyc = 0;
    logic [15:0] ref_lfsr;
    int          got_s[$], got_o[$];
    int          seq_a[$], seq_b[$];

    int m_deck[52];
    bit m_valid = 0, o_valid = 0;
    int m_ready, m_left, m_ptr;
    int o_ready, o_left, o_ptr;

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        ref_lfsr <= reset ? 16'hACE1 : lstep(ref_lfsr);
    end

    task automatic chk(input string nm, input logic [15:0] act, input int exp);
        n_vec++;
        if (act !== 16'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (sq.size() > 0 && sq[0].cyc < cyc) begin
            n_vec++; n_bad++;
            $display("FAIL s_missing: no pulse at cycle %0d, expected err=%0b card=%0d",
                     sq[0].cyc, sq[0].err, sq[0].card);
            void'(sq.pop_front());
        end
        if (s_if.deal_valid === 1'b1 || s_if.deal_err === 1'b1) begin
            n_vec++;
            if (sq.size() == 0 || sq[0].cyc != cyc) begin
                n_bad++;
                $display("FAIL s_unexpected: valid=%b err=%b card=%0d at cycle %0d, expected none",
                         s_if.deal_valid, s_if.deal_err, s_if.deal_card, cyc);
            end else begin
                es = sq.pop_front();
                if (s_if.deal_err !== es.err || s_if.deal_valid !== !es.err ||
                    (!es.err && s_if.deal_card !== es.card)) begin
                    n_bad++;
                    $display("FAIL s_deal: got valid=%b err=%b card=%0d, expected err=%0b card=%0d",
                             s_if.deal_valid, s_if.deal_err, s_if.deal_card, es.err, es.card);
                end
            end
            if (s_if.deal_valid === 1'b1) got_s.push_back(int'(s_if.deal_card));
        end
    end

    always @(negedge clk) begin
        if (oq.size() > 0 && oq[0].cyc < cyc) begin
            n_vec++; n_bad++;
            $display("FAIL o_missing: no pulse at cycle %0d, expected err=%0b card=%0d",
                     oq[0].cyc, oq[0].err, oq[0].card);
            void'(oq.pop_front());
        end
        if (o_if.deal_valid === 1'b1 || o_if.deal_err === 1'b1) begin
            n_vec++;
            if (oq.size() == 0 || oq[0].cyc != cyc) begin
                n_bad++;
                $display("FAIL o_unexpected: valid=%b err=%b card=%0d at cycle %0d, expected none",
                         o_if.deal_valid, o_if.deal_err, o_if.deal_card, cyc);
            end else begin
                eo = oq.pop_front();
                if (o_if.deal_err !== eo.err || o_if.deal_valid !== !eo.err ||
                    (!eo.err && o_if.deal_card !== eo.card)) begin
                    n_bad++;
                    $display("FAIL o_deal: got valid=%b err=%b card=%0d, expected err=%0b card=%0d",
                             o_if.deal_valid, o_if.deal_err, o_if.deal_card, eo.err, eo.card);
                end
            end
            if (o_if.deal_valid === 1'b1) got_o.push_back(int'(o_if.deal_card));
        end
    end

    task automatic clear_inputs();
        s_if.shuffle_start = 1'b0; s_if.deal_req = 1'b0;
        o_if.shuffle_start = 1'b0; o_if.deal_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clear_inputs();
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        s_if.deal_req = 1'b1;  // a request inside reset must produce no pulse
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        m_valid = 0; o_valid = 0;
        chk("rst_ready", s_if.ready, 0);
        chk("rst_busy", s_if.busy, 0);
        chk("rst_cards_left", s_if.cards_left, 0);
        chk("rst_deal_card", s_if.deal_card, 0);
        chk("rst_pulses", {s_if.deal_valid, s_if.deal_err}, 0);
    endtask

    // Reference shuffle: identity deck, then Fisher-Yates with rejection on the
    // LFSR values seen from the first cycle after the 52-cycle rebuild.
    task automatic start_s(input bit with_req);
        logic [15:0] l;
        int n, j, m, tmp;
        @(negedge clk);
        s_if.shuffle_start = 1'b1;
        s_if.deal_req = with_req;
        if (with_req) sq.push_back('{cyc: cyc + 1, err: 1'b1, card: 6'd0});
        l = ref_lfsr;
        repeat (53) l = lstep(l);
        for (int k = 0; k < 52; k++) m_deck[k] = k;
        n = 0;
        for (int i = 51; i >= 1; i--) begin
            m = 1;
            while (m < i) m = m * 2 + 1;
            do begin
                j = int'(l[5:0]) & m;
                l = lstep(l);
                n++;
            end while (j > i);
            tmp = m_deck[i]; m_deck[i] = m_deck[j]; m_deck[j] = tmp;
        end
        m_valid = 1; m_ready = cyc + 53 + n; m_left = 52; m_ptr = 0;
        @(negedge clk);
        clear_inputs();
        chk("start_busy", s_if.busy, 1);
        chk("start_ready", s_if.ready, 0);
        chk("start_cards_left", s_if.cards_left, 0);
    endtask

    task automatic wait_ready_s();
        while (cyc < m_ready - 1) begin
            @(negedge clk);
            clear_inputs();
        end
        chk("s_busy_before_ready", s_if.busy, 1);
        chk("s_ready_before_ready", s_if.ready, 0);
        @(negedge clk);
        chk("s_ready", s_if.ready, 1);
        chk("s_busy_after", s_if.busy, 0);
        chk("s_cards_left_full", s_if.cards_left, 52);
    endtask

    task automatic deal_s();
        @(negedge clk);
        s_if.shuffle_start = 1'b0;
        s_if.deal_req = 1'b1;
        if (m_valid && cyc >= m_ready && m_left > 0) begin
            sq.push_back('{cyc: cyc + 1, err: 1'b0, card: 6'(m_deck[m_ptr])});
            m_ptr++; m_left--;
        end else begin
            sq.push_back('{cyc: cyc + 1, err: 1'b1, card: 6'd0});
        end
    endtask

    task automatic deal_o();
        @(negedge clk);
        o_if.deal_req = 1'b1;
        if (o_valid && cyc >= o_ready && o_left > 0) begin
            oq.push_back('{cyc: cyc + 1, err: 1'b0, card: 6'(o_ptr)});
            o_ptr++; o_left--;
        end else begin
            oq.push_back('{cyc: cyc + 1, err: 1'b1, card: 6'd0});
        end
    endtask

    task automatic check_perm(input string nm, input int q[$]);
        bit seen[52];
        int dups = 0, bad = 0, ident = 1;
        foreach (seen[k]) seen[k] = 0;
        foreach (q[k]) begin
            if (q[k] < 0 || q[k] > 51) bad++;
            else if (seen[q[k]]) dups++;
            else seen[q[k]] = 1;
            if (q[k] != k) ident = 0;
        end
        chk({nm, "_count"}, 16'(q.size()), 52);
        chk({nm, "_range"}, 16'(bad), 0);
        chk({nm, "_dups"}, 16'(dups), 0);
        chk({nm, "_not_identity"}, 16'(ident), 0);
    endtask

    task automatic full_deal_s(input string nm);
        got_s.delete();
        repeat (52) deal_s();
        deal_s();  // one past empty
        idle(2);
        chk({nm, "_left_empty"}, s_if.cards_left, 0);
        check_perm(nm, got_s);
    endtask

    function automatic int ndiff(input int a[$], input int b[$]);
        int d = 0;
        if (a.size() != b.size()) return 52;
        foreach (a[k]) if (a[k] != b[k]) d++;
        return d;
    endfunction

    initial begin
        clear_inputs();
        do_reset(2);

        // Request while idle
        deal_s();
        idle(2);

        // In-order deck
        @(negedge clk);
        o_if.shuffle_start = 1'b1;
        o_valid = 1; o_ready = cyc + 53; o_left = 52; o_ptr = 0;
        @(negedge clk);
        clear_inputs();
        chk("o_start_busy", o_if.busy, 1);
        while (cyc < o_ready - 1) idle(1);
        chk("o_ready_early", o_if.ready, 0);
        idle(1);
        chk("o_ready_t53", o_if.ready, 1);
        chk("o_busy_t53", o_if.busy, 0);
        got_o.delete();
        repeat (52) deal_o();
        deal_o();
        idle(2);
        chk("o_left_empty", o_if.cards_left, 0);
        chk("o_card_hold", o_if.deal_card, 51);
        chk("o_count", 16'(got_o.size()), 52);

        // Shuffle from a fixed offset, then one cycle later
        do_reset(2);
        idle(5);
        start_s(1'b0);
        wait_ready_s();
        full_deal_s("perm_a");
        seq_a = got_s;

        do_reset(2);
        idle(6);
        start_s(1'b0);
        wait_ready_s();
        full_deal_s("perm_b");
        seq_b = got_s;
        chk("offset_differs", 16'(ndiff(seq_a, seq_b) > 0), 1);

        // Reset mid-shuffle, then repeat the first run
        do_reset(2);
        idle(5);
        start_s(1'b0);
        idle(60);
        chk("mid_shuffle_busy", s_if.busy, 1);
        do_reset(2);
        idle(5);
        start_s(1'b0);
        wait_ready_s();
        full_deal_s("perm_c");
        chk("reset_repeat_same", 16'(ndiff(seq_a, got_s)), 0);

        // Restart mid-shuffle at a random point
        start_s(1'b0);
        idle(53 + $urandom_range(0, 40));
        start_s(1'b0);
        wait_ready_s();
        full_deal_s("perm_restart_busy");

        // Restart after 9 cards
        start_s(1'b0);
        wait_ready_s();
        repeat (9) deal_s();
        idle($urandom_range(1, 4));
        chk("left_after_9", s_if.cards_left, 43);
        start_s(1'b0);
        wait_ready_s();
        full_deal_s("perm_restart_9");

        // Collision of shuffle_start and deal_req in READY
        start_s(1'b0);
        wait_ready_s();
        repeat ($urandom_range(1, 5)) deal_s();
        start_s(1'b1);
        wait_ready_s();
        full_deal_s("perm_collide");

        idle(3);
        chk("sb_drained", 16'(sq.size() + oq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
